rggen_pipelined_mux: RTL

//  Registered one-hot AND-OR multiplexer with valid/ready flow control, for wide register-read

---
 rtl/rggen_pipelined_mux.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/rggen_pipelined_mux.sv
// rtl/rggen_pipelined_mux.sv - registered one-hot AND-OR mux with valid/ready pipeline
// Reduction tree of radix FANIN, registered every LEVELS_PER_STAGE levels; hit/error travel with each beat.
module rggen_pipelined_mux #(
  parameter int WIDTH            = 32,
  parameter int ENTRIES          = 8,
  parameter int FANIN            = 4,
  parameter int LEVELS_PER_STAGE = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [ENTRIES-1:0]         i_select,
  input  logic [ENTRIES*WIDTH-1:0]   i_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_hit,
  output logic                       o_select_error,
  input  logic                       i_clear_error,
  output logic                       o_error_sticky
);

  function automatic int calc_levels(input int n);
    int c;
    int l;
    c = n;
    l = 0;
    while (c > 1) begin
      c = (c + FANIN - 1) / FANIN;
      l++;
    end
    return l;
  endfunction

  function automatic int nodes_at(input int lvl);
    int c;
    c = ENTRIES;
    for (int i = 0; i < lvl; i++) c = (c + FANIN - 1) / FANIN;
    return c;
  endfunction

  localparam int LEVELS  = calc_levels(ENTRIES);
  localparam int LATENCY = (LEVELS == 0) ? 1 : (LEVELS + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

  function automatic bit is_boundary(input int lvl);
    if (LEVELS == 0) return 1'b1;
    return (lvl > 0) && (((lvl % LEVELS_PER_STAGE) == 0) || (lvl == LEVELS));
  endfunction

  function automatic int stage_of(input int lvl);
    if (LEVELS == 0) return 0;
    return (lvl + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE - 1;
  endfunction

  logic [LATENCY-1:0] valid_q;
  logic [LATENCY-1:0] hit_q;
  logic [LATENCY-1:0] err_q;
  logic [LATENCY-1:0] valid_d;
  logic [LATENCY-1:0] hit_d;
  logic [LATENCY-1:0] err_d;
  logic [LATENCY-1:0] stage_ready;
  logic               in_hit;
  logic               in_err;
  logic               accept;
  logic               err_sticky_q;

  assign in_hit = |i_select;
  assign in_err = |(i_select & (i_select - 1'b1));

  // A stage may load if the output is taken or any stage at or after it holds a bubble.
  always_comb begin
    stage_ready = '0;
    for (int s = 0; s < LATENCY; s++) begin
      stage_ready[s] = i_ready;
      for (int k = s; k < LATENCY; k++) begin
        if (!valid_q[k]) stage_ready[s] = 1'b1;
      end
    end
  end

  assign o_ready = stage_ready[0] && !i_rst;
  assign accept  = i_valid && o_ready;

  for (genvar s = 0; s < LATENCY; s++) begin : g_stage_in
    if (s == 0) begin : g_first
      assign valid_d[s] = i_valid;
      assign hit_d[s]   = in_hit;
      assign err_d[s]   = in_err;
    end else begin : g_next
      assign valid_d[s] = valid_q[s-1];
      assign hit_d[s]   = hit_q[s-1];
      assign err_d[s]   = err_q[s-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= '0;
      hit_q   <= '0;
      err_q   <= '0;
    end else begin
      for (int s = 0; s < LATENCY; s++) begin
        if (stage_ready[s]) begin
          valid_q[s] <= valid_d[s];
          hit_q[s]   <= hit_d[s];
          err_q[s]   <= err_d[s];
        end
      end
    end
  end

  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int N = nodes_at(l);
    logic [N*WIDTH-1:0] node_comb;
    logic [N*WIDTH-1:0] node_out;

    if (l == 0) begin : g_mask
      for (genvar i = 0; i < N; i++) begin : g_m
        assign node_comb[i*WIDTH +: WIDTH] = {WIDTH{i_select[i]}} & i_data[i*WIDTH +: WIDTH];
      end
    end else begin : g_or
      localparam int NP = nodes_at(l - 1);
      for (genvar j = 0; j < N; j++) begin : g_node
        localparam int LO  = j * FANIN;
        localparam int CNT = ((NP - LO) < FANIN) ? (NP - LO) : FANIN;
        logic [WIDTH-1:0] acc;
        always_comb begin
          acc = '0;
          for (int k = 0; k < CNT; k++) acc = acc | g_lvl[l-1].node_out[(LO+k)*WIDTH +: WIDTH];
        end
        assign node_comb[j*WIDTH +: WIDTH] = acc;
      end
    end

    if (is_boundary(l)) begin : g_reg
      localparam int S = stage_of(l);
      logic [N*WIDTH-1:0] node_q;
      always_ff @(posedge i_clk) begin
        if (i_rst) node_q <= '0;
        else if (stage_ready[S]) node_q <= node_comb;
      end
      assign node_out = node_q;
    end else begin : g_pass
      assign node_out = node_comb;
    end
  end

  // Clear is applied first so a same-cycle multi-hot acceptance overrides it.
  always_ff @(posedge i_clk) begin
    if (i_rst) err_sticky_q <= 1'b0;
    else if (accept && in_err) err_sticky_q <= 1'b1;
    else if (i_clear_error) err_sticky_q <= 1'b0;
  end

  assign o_valid        = valid_q[LATENCY-1];
  assign o_hit          = hit_q[LATENCY-1];
  assign o_select_error = err_q[LATENCY-1];
  assign o_data         = g_lvl[LEVELS].node_out[WIDTH-1:0];
  assign o_error_sticky = err_sticky_q;

endmodule
